oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
Sequences the NES sprite DMA triggered by a CPU write to $4014. It copies the 256-byte CPU page {page,8'h00}..{page,8'hFF} from cpu_memory into PPU OAM as alternating read/write cycles, and stalls the CPU for 513 or 514 cycles. While active it owns the cpu_memory main port: dma_active selects the DMA address in the top-level mux and deasserts CPU RDY.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU address whose write triggers DMA
OAM_BYTES, 256, bytes per transfer; fixed, sizes the 8-bit index

Ports:
CLK  input  1  system clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
cpu_w  input  1  CPU write strobe (snooped)
cpu_address  input  16  CPU bus address (snooped)
cpu_data  input  8  CPU write data (snooped)
oam_start  input  8  current OAMADDR ($2003) value, sampled at trigger
mem_data  input  8  cpu_memory `out`; valid in the same cycle as the read
dma_active  output  1  DMA owns memory port; CPU stalled
mem_r  output  1  read request to cpu_memory
mem_address  output  16  read address to cpu_memory
oam_w  output  1  OAM write strobe
oam_address  output  8  OAM write address
oam_data  output  8  OAM write data

Behaviour:
- Reset: state=IDLE. dma_active, mem_r, oam_w=0. mem_address=16'h0000, oam_address=8'h00, oam_data=8'h00. Parity flop par=0. idx=0.
- par toggles every cycle after reset. The DMA never resets it.
- Trigger: in IDLE, the cycle cpu_w=1 && cpu_address==DMA_REG_ADDR latches page=cpu_data, base=oam_start, idx=0, and goes to ALIGN. dma_active=1 from the next cycle.
- States:
  - IDLE
  - ALIGN: dummy cycle, no mem_r/oam_w. If par==1 in this cycle, go to READ. Otherwise go to ALIGN2.
  - ALIGN2: one extra dummy cycle, then READ.
  - READ: occurs only on par==0. mem_r=1, mem_address={page,idx}. mem_data is latched into a byte register at the rising edge. Next state is WRITE.
  - WRITE: oam_w=1, oam_address=base+idx (8-bit wrap), oam_data=latched byte. If idx==8'hFF, go to IDLE. Otherwise idx++ and go to READ.
- Stall length, counting trigger cycle as T:
  - par(T)=0 → dma_active high for cycles T+1..T+513.
  - par(T)=1 → dma_active high for cycles T+1..T+514.
- dma_active, mem_r and oam_w are registered and glitch-free.
- mem_r and oam_w are never both high.
- Outputs outside DMA:
  - mem_address holds its last value; the top level ignores it when dma_active=0.
  - oam_w=0.
- Boundaries:
  - Writes to $4014 while dma_active=1 are ignored: no re-latch, no restart.
  - A trigger on the same cycle as the final WRITE is ignored, because the state is not IDLE.
  - oam_start changes after the trigger have no effect.
  - oam_address wraps FF→00 when base≠0. Exactly 256 oam_w pulses per DMA.
  - page=8'h00..8'h07 reads the mirrored RAM region; the address is passed through unmodified, and cpu_memory does the mirroring.
  - RESET mid-DMA: the next cycle is IDLE with reset outputs and no further oam_w. A partial OAM update is acceptable.
  - RESET and a trigger in the same cycle: reset wins.

Test Plan:
1. Reset, preload RAM $0200-$02FF with byte=addr[7:0]^8'h5A. Write 8'h02 to $4014 on a par=0 cycle with oam_start=0 → dma_active high exactly 513 cycles. 256 oam_w pulses: oam_address 0..255, oam_data[i]=i^8'h5A, first read address 16'h0200.
2. Same transfer triggered on a par=1 cycle → dma_active high exactly 514 cycles; data identical.
3. oam_start=8'hF0, page=8'h03 → first write oam_address=F0 with data from $0300. Address wraps to 00 at the 17th write; last write oam_address=EF with data from $03FF.
4. Second $4014 write (data 8'h05) at cycle T+100 of an active DMA → no restart, mem_address high byte stays 8'h03, total stall unchanged.
5. Assert RESET at cycle T+200 → next cycle dma_active=0, oam_w=0, mem_r=0. No further OAM writes. A fresh trigger afterwards completes normally.
6. page=8'h08 (mirror of $0000) → mem_address 16'h0800..16'h08FF. OAM receives RAM $0000-$00FF contents.

Source files
------------

// File: rtl/oam_dma_controller.sv
// oam_dma_controller
//   Sequences the sprite DMA started by a CPU write to DMA_REG_ADDR. It copies
//   the 256-byte CPU page {page,00}..{page,FF} into OAM using alternating
//   read/write cycles. It holds the memory port, and so stalls the CPU, for
//   513 or 514 cycles, depending on the bus parity at the trigger.
//
// Ports
//   CLK, RESET              clock; synchronous active-high reset
//   cpu_w, cpu_address,     snooped CPU write bus
//   cpu_data
//   oam_start               current OAMADDR, sampled at trigger
//   mem_data                cpu_memory read data, valid in the read cycle
//   dma_active              DMA owns the memory port (CPU RDY low)
//   mem_r, mem_address      read request to cpu_memory
//   oam_w, oam_address,     OAM write port
//   oam_data
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a write to DMA_REG_ADDR
// ALIGN  | first dummy cycle; skips ALIGN2 when already on odd parity
// ALIGN2 | extra dummy cycle so that reads land on even parity
// READ   | mem_r asserted for {page,idx}; byte latched at the edge
// WRITE  | oam_w asserted for base+idx; ends after idx == last index
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter int          OAM_BYTES    = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_w,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic [7:0]  oam_start,
  input  logic [7:0]  mem_data,
  output logic        dma_active,
  output logic        mem_r,
  output logic [15:0] mem_address,
  output logic        oam_w,
  output logic [7:0]  oam_address,
  output logic [7:0]  oam_data
);

  localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, ALIGN, ALIGN2, READ, WRITE} state_t;

  state_t      state, state_n;
  logic        par;
  logic [7:0]  page, base, idx, idx_rd;
  logic        trigger;

  logic        dma_active_d, mem_r_d, oam_w_d;
  logic [15:0] mem_address_d;
  logic [7:0]  oam_address_d, oam_data_d;

  assign trigger = (state == IDLE) && cpu_w && (cpu_address == DMA_REG_ADDR);

  // State register. Outputs are registered from next-state decode so the
  // strobes and dma_active come straight off flops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      par         <= 1'b0;
      page        <= 8'h00;
      base        <= 8'h00;
      idx         <= 8'h00;
      dma_active  <= 1'b0;
      mem_r       <= 1'b0;
      oam_w       <= 1'b0;
      mem_address <= 16'h0000;
      oam_address <= 8'h00;
      oam_data    <= 8'h00;
    end else begin
      state       <= state_n;
      par         <= ~par;
      dma_active  <= dma_active_d;
      mem_r       <= mem_r_d;
      oam_w       <= oam_w_d;
      mem_address <= mem_address_d;
      oam_address <= oam_address_d;
      oam_data    <= oam_data_d;
      if (trigger) begin
        page <= cpu_data;
        base <= oam_start;
        idx  <= 8'h00;
      end else if (state == WRITE && idx != LAST_IDX) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (trigger) state_n = ALIGN;
      ALIGN:   state_n = par ? READ : ALIGN2;
      ALIGN2:  state_n = READ;
      READ:    state_n = WRITE;
      WRITE:   state_n = (idx == LAST_IDX) ? IDLE : READ;
      default: state_n = IDLE;
    endcase
  end

  // Values loaded into the output flops at the coming edge. A READ entered
  // from WRITE uses the index the WRITE is about to advance to.
  always_comb begin
    dma_active_d  = (state_n != IDLE);
    mem_r_d       = (state_n == READ);
    oam_w_d       = (state_n == WRITE);
    idx_rd        = (state == WRITE) ? idx + 8'd1 : idx;
    mem_address_d = mem_address;
    oam_address_d = oam_address;
    oam_data_d    = oam_data;
    if (state_n == READ) mem_address_d = {page, idx_rd};
    if (state == READ) begin
      oam_address_d = base + idx;
      oam_data_d    = mem_data;
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
module tb_oam_dma_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cpu_w;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data;
  logic [7:0]  oam_start;
  logic [7:0]  mem_data;
  logic        dma_active, mem_r, oam_w;
  logic [15:0] mem_address;
  logic [7:0]  oam_address, oam_data;

  int checks = 0;
  int failures = 0;
  logic par_m;

  oam_dma_controller dut (
    .CLK(CLK), .RESET(RESET), .cpu_w(cpu_w), .cpu_address(cpu_address),
    .cpu_data(cpu_data), .oam_start(oam_start), .mem_data(mem_data),
    .dma_active(dma_active), .mem_r(mem_r), .mem_address(mem_address),
    .oam_w(oam_w), .oam_address(oam_address), .oam_data(oam_data)
  );

  always #5 CLK = ~CLK;

  // Reference bus parity.
  always_ff @(posedge CLK) par_m <= RESET ? 1'b0 : ~par_m;

  // cpu_memory model: 2 KB RAM mirrored below $2000.
  // RAM $0000-$00FF holds addr^C3, the rest holds addr^5A.
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    logic [15:0] m;
    m = a & 16'h07FF;
    if (a < 16'h2000) return (m < 16'h0100) ? (m[7:0] ^ 8'hC3) : (m[7:0] ^ 8'h5A);
    return 8'h00;
  endfunction

  assign mem_data = mem_r ? mem_fn(mem_address) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] page;
    logic [7:0] start;
    logic       want_par;
    int         exp_len;
    int         exp_writes;
    logic [7:0] xr;
    bit         second;
    int         rst_at;
    bit         end_trig;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h02, 8'h00, 1'b0, 513, 256, 8'h5A, 1'b0, 0,   1'b0};
    vecs[1] = '{8'h02, 8'h00, 1'b1, 514, 256, 8'h5A, 1'b0, 0,   1'b1};
    vecs[2] = '{8'h03, 8'hF0, 1'b0, 513, 256, 8'h5A, 1'b0, 0,   1'b0};
    vecs[3] = '{8'h03, 8'h10, 1'b1, 514, 256, 8'h5A, 1'b1, 0,   1'b0};
    vecs[4] = '{8'h02, 8'h00, 1'b0, 200, 99,  8'h5A, 1'b0, 200, 1'b0};
    vecs[5] = '{8'h02, 8'h00, 1'b1, 514, 256, 8'h5A, 1'b0, 0,   1'b0};
    vecs[6] = '{8'h08, 8'h00, 1'b0, 513, 256, 8'hC3, 1'b0, 0,   1'b0};

    RESET = 1'b1; cpu_w = 1'b0; cpu_address = 16'h0000; cpu_data = 8'h00; oam_start = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dma_active", dma_active, 0);
    chk("rst_mem_r", mem_r, 0);
    chk("rst_oam_w", oam_w, 0);
    chk("rst_mem_address", mem_address, 16'h0000);
    chk("rst_oam_address", oam_address, 8'h00);
    chk("rst_oam_data", oam_data, 8'h00);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    for (int n = 0; n < 7; n++) begin
      int act_cnt, first, nwr;
      bit excl_bad;
      vec_t v;
      v = vecs[n];
      act_cnt = 0; first = 0; nwr = 0; excl_bad = 0;
      @(negedge CLK);
      for (int w = 0; w < 4 && par_m !== v.want_par; w++) @(negedge CLK);
      cpu_w = 1'b1; cpu_address = 16'h4014; cpu_data = v.page; oam_start = v.start;
      for (int i = 1; i <= 540; i++) begin
        @(negedge CLK);
        if (i == 1) begin
          cpu_w = 1'b0; cpu_address = 16'h4000; oam_start = 8'h77;
        end
        if (v.rst_at != 0 && i == v.rst_at + 1) begin
          chk("post_rst_dma_active", dma_active, 0);
          chk("post_rst_oam_w", oam_w, 0);
          chk("post_rst_mem_r", mem_r, 0);
          chk("post_rst_mem_address", mem_address, 16'h0000);
          RESET = 1'b0;
        end
        if (dma_active === 1'b1) begin
          act_cnt++;
          if (first == 0) first = i;
        end
        if (mem_r === 1'b1 && oam_w === 1'b1) excl_bad = 1;
        if (mem_r === 1'b1) chk("read_address", mem_address, {v.page, 8'(nwr)});
        if (oam_w === 1'b1) begin
          chk("oam_address", oam_address, 8'(v.start + 8'(nwr)));
          chk("oam_data", oam_data, 8'(nwr) ^ v.xr);
          nwr++;
        end
        if (v.second && i == 100) begin
          cpu_w = 1'b1; cpu_address = 16'h4014; cpu_data = 8'h05;
        end
        if (v.second && i == 101) cpu_w = 1'b0;
        if (v.end_trig && i == v.exp_len) begin
          cpu_w = 1'b1; cpu_address = 16'h4014; cpu_data = v.page;
        end
        if (v.end_trig && i == v.exp_len + 1) cpu_w = 1'b0;
        if (v.rst_at != 0 && i == v.rst_at) RESET = 1'b1;
      end
      chk($sformatf("stall_len_%0d", n), act_cnt, v.exp_len);
      chk($sformatf("first_active_%0d", n), first, 1);
      chk($sformatf("write_count_%0d", n), nwr, v.exp_writes);
      chk($sformatf("r_w_exclusive_%0d", n), excl_bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
